// File: rtl/rc4_cracker_pkg.sv
// Shared types and defaults for the RC4 key-space dispatcher.
// Optional feature macro used by the dispatcher: RC4_DISPATCH_ABORT_EN.
package rc4_cracker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE_OK,
        DONE_FAIL
    } state_t;

    localparam int          DEF_KEY_WIDTH = 24;
    localparam logic [23:0] DEF_KEY_MAX   = 24'h3FFFFF;

    // Index width for an N-entry select; a single entry still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc4_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest request and a valid flag.
module rc4_prio_enc
    import rc4_cracker_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rc4_key_dispatcher.sv
// Dynamic key dispatcher for NUM_CORES external RC4 decrypt/check cores.
// Hands the next untested key to the lowest-index idle core, one key per cycle,
// and reports the first key whose plaintext passes, or failure on exhaustion.
// Optional feature macro: RC4_DISPATCH_ABORT_EN (abort losers on success instead
// of draining them through FLUSH).
module rc4_key_dispatcher
    import rc4_cracker_pkg::*;
#(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = DEF_KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(DEF_KEY_MAX)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rc4_start,
    output logic                           rc4_ready,
    output logic                           rc4_finish,
    output logic                           rc4_failure,
    output logic [KEY_WIDTH-1:0]           current_key,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_success,
    output logic [NUM_CORES-1:0]           core_abort
);

    localparam int IDX_W = idx_w(NUM_CORES);
    // One extra counter bit so an all-ones KEY_MAX ends the sweep instead of wrapping.
    localparam logic [KEY_WIDTH:0] LIMIT = {1'b0, KEY_MAX};

    state_t                 state, state_nx;
    logic [NUM_CORES-1:0]   busy, busy_nx;
    logic [KEY_WIDTH:0]     cnt;
    logic [KEY_WIDTH-1:0]   key_q [NUM_CORES];
    logic [KEY_WIDTH-1:0]   win_key;

    logic [NUM_CORES-1:0]   idle_vec, win_vec, disp_vec;
    logic [IDX_W-1:0]       idle_idx, win_idx;
    logic                   idle_vld, win_vld;
    logic                   accept, keys_left, dispatch;
    logic                   ready_nx, finish_nx, failure_nx;

    assign idle_vec  = ~busy;
    // Completions only count as winners while sweeping; FLUSH ignores them.
    assign win_vec   = (state == RUN) ? (core_done & core_success & busy) : '0;
    assign keys_left = (cnt <= LIMIT);
    assign accept    = rc4_start &&
                       (state == IDLE || state == DONE_OK || state == DONE_FAIL);
    // A success in this cycle suppresses dispatch so no key past the winner leaks out.
    assign dispatch  = (state == RUN) && !win_vld && keys_left && idle_vld;

    rc4_prio_enc #(.WIDTH(NUM_CORES), .IDX_W(IDX_W)) u_idle_sel (
        .req   (idle_vec),
        .idx   (idle_idx),
        .valid (idle_vld)
    );

    rc4_prio_enc #(.WIDTH(NUM_CORES), .IDX_W(IDX_W)) u_win_sel (
        .req   (win_vec),
        .idx   (win_idx),
        .valid (win_vld)
    );

    // One-hot dispatch target and the key held by the winning core.
    always_comb begin
        disp_vec = '0;
        win_key  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            disp_vec[i] = dispatch && (IDX_W'(i) == idle_idx);
            if (IDX_W'(i) == win_idx) win_key = key_q[i];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE_OK, DONE_FAIL: if (rc4_start) state_nx = RUN;
            RUN: begin
                if (win_vld) begin
`ifdef RC4_DISPATCH_ABORT_EN
                    state_nx = DONE_OK;
`else
                    state_nx = FLUSH;
`endif
                end else if (!keys_left && busy == '0) begin
                    state_nx = DONE_FAIL;
                end
            end
            FLUSH:   if (busy == '0) state_nx = DONE_OK;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: next busy map and next status flags.
    always_comb begin
        busy_nx    = busy;
        ready_nx   = (state_nx == IDLE) || (state_nx == DONE_OK) || (state_nx == DONE_FAIL);
        finish_nx  = (state_nx == DONE_OK);
        failure_nx = (state_nx == DONE_FAIL);
        if (accept) begin
            busy_nx = '0;
        end else if (state == RUN || state == FLUSH) begin
            busy_nx = (busy & ~core_done) | disp_vec;
`ifdef RC4_DISPATCH_ABORT_EN
            if (win_vld) busy_nx = '0;
`endif
        end
    end

    // Status flags are registered so they assert the cycle after the deciding condition.
    always_ff @(posedge clk) begin
        if (reset) begin
            rc4_ready   <= 1'b1;
            rc4_finish  <= 1'b0;
            rc4_failure <= 1'b0;
        end else begin
            rc4_ready   <= ready_nx;
            rc4_finish  <= finish_nx;
            rc4_failure <= failure_nx;
        end
    end

    // Key counter, busy map, dispatch pulses, per-core keys and winner capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            busy        <= '0;
            core_start  <= '0;
            current_key <= '0;
            found_key   <= '0;
            for (int i = 0; i < NUM_CORES; i++) key_q[i] <= '0;
        end else begin
            busy       <= busy_nx;
            core_start <= disp_vec;
            if (accept) begin
                cnt <= '0;
            end else if (dispatch) begin
                cnt         <= cnt + 1'b1;
                current_key <= cnt[KEY_WIDTH-1:0];
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (disp_vec[i]) key_q[i] <= cnt[KEY_WIDTH-1:0];
            end
            if (win_vld) found_key <= win_key;
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_key
        assign core_key[g*KEY_WIDTH +: KEY_WIDTH] = key_q[g];
    end

`ifdef RC4_DISPATCH_ABORT_EN
    // On success, stop every other core still working; the winner has already finished.
    always_ff @(posedge clk) begin
        if (reset) core_abort <= '0;
        else       core_abort <= win_vld ? (busy & ~core_done) : '0;
    end
`else
    assign core_abort = '0;
`endif

endmodule

// File: tb/tb_rc4_key_dispatcher.sv
// Bench for rc4_key_dispatcher: behavioural core models plus a cycle-level
// reference of the dispatch rules, with directed sweeps and literal pins.
module tb_rc4_key_dispatcher;

    localparam int NC     = 4;
    localparam int KW     = 6;
    localparam int KMAX_I = 63;

    logic                clk, reset, rc4_start;
    logic                rc4_ready, rc4_finish, rc4_failure;
    logic [KW-1:0]       current_key, found_key;
    logic [NC-1:0]       core_start, core_done, core_success, core_abort;
    logic [NC*KW-1:0]    core_key;

    // Second, narrow instance: 4-bit keys, all-ones KEY_MAX, single core.
    logic       rst_b, start_b, ready_b, finish_b, failure_b;
    logic [3:0] cur_b, found_b, ck_b;
    logic [0:0] cs_b, cd_b, csucc_b, ca_b;

    rc4_key_dispatcher #(.NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_MAX(6'h3F)) dut (
        .clk(clk), .reset(reset), .rc4_start(rc4_start), .rc4_ready(rc4_ready),
        .rc4_finish(rc4_finish), .rc4_failure(rc4_failure), .current_key(current_key),
        .found_key(found_key), .core_start(core_start), .core_key(core_key),
        .core_done(core_done), .core_success(core_success), .core_abort(core_abort)
    );

    rc4_key_dispatcher #(.NUM_CORES(1), .KEY_WIDTH(4), .KEY_MAX(4'hF)) dut_b (
        .clk(clk), .reset(rst_b), .rc4_start(start_b), .rc4_ready(ready_b),
        .rc4_finish(finish_b), .rc4_failure(failure_b), .current_key(cur_b),
        .found_key(found_b), .core_start(cs_b), .core_key(ck_b),
        .core_done(cd_b), .core_success(csucc_b), .core_abort(ca_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model state
    int  edge_n = 0;
    bit  m_ready, m_fin, m_fail, running, succ_seen, term_set, term_ok;
    int  term_edge, accept_edge, next_key, exp_cur, exp_found;
    int  key_of [NC];
    bit  bsy [NC];
    int  done_edge [NC];
    int  lat [NC];
    int  succ_mode = 0;
    logic [NC-1:0] drv_done, drv_succ;
    int  obs_cnt, obs_max, dup;
    bit  seen [64];

    function automatic bit is_succ(input int k);
        case (succ_mode)
            1:       return k == 37;
            2:       return (k == 1) || (k == 3);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        running = 0; m_ready = 1; m_fin = 0; m_fail = 0;
        term_set = 0; succ_seen = 0; next_key = 0; exp_cur = 0; exp_found = 0;
        for (int i = 0; i < NC; i++) begin
            bsy[i] = 0; key_of[i] = 0; done_edge[i] = 0;
        end
    endtask

    // One clock: advance the model for the edge just taken, compare, drive core responses.
    task automatic tick();
        bit s_start, s_reset, accept, idle;
        int lo, k;
        logic [NC-1:0] exp_start;
        s_start = rc4_start;
        s_reset = reset;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        exp_start = '0;
        if (s_reset) begin
            model_reset();
        end else begin
            accept = s_start && m_ready;
            if (running && term_set && edge_n == term_edge) begin
                running = 0; m_ready = 1; m_fin = term_ok; m_fail = !term_ok;
            end
            if (accept) begin
                running = 1; term_set = 0; succ_seen = 0; next_key = 0;
                accept_edge = edge_n; m_ready = 0; m_fin = 0; m_fail = 0;
                obs_cnt = 0; obs_max = -1; dup = 0;
                for (int i = 0; i < 64; i++) seen[i] = 0;
            end
            // A core finishing at an edge may take a new key from the following edge.
            for (int i = 0; i < NC; i++)
                if (bsy[i] && done_edge[i] == edge_n - 1) bsy[i] = 0;
            if (running && !succ_seen && (drv_done & drv_succ) != '0) begin
                succ_seen = 1;
                for (int i = NC - 1; i >= 0; i--)
                    if (drv_done[i] && drv_succ[i]) exp_found = key_of[i];
            end
            if (running && !succ_seen && next_key <= KMAX_I && edge_n >= accept_edge + 1) begin
                lo = -1;
                for (int i = NC - 1; i >= 0; i--) if (!bsy[i]) lo = i;
                if (lo >= 0) begin
                    exp_start[lo] = 1'b1;
                    bsy[lo] = 1; key_of[lo] = next_key;
                    done_edge[lo] = edge_n + lat[lo];
                    exp_cur = next_key;
                    next_key++;
                end
            end
            if (running && !term_set) begin
                idle = 1;
                for (int i = 0; i < NC; i++) if (bsy[i] && done_edge[i] > edge_n) idle = 0;
                if (idle && (succ_seen || next_key > KMAX_I)) begin
                    term_set = 1; term_edge = edge_n + 1; term_ok = succ_seen;
                end
            end
        end
        chk("rc4_ready",   rc4_ready,   m_ready);
        chk("rc4_finish",  rc4_finish,  m_fin);
        chk("rc4_failure", rc4_failure, m_fail);
        chk("core_start",  core_start,  exp_start);
        chk("current_key", current_key, exp_cur);
        chk("found_key",   found_key,   exp_found);
        chk("core_abort",  core_abort,  0);
        for (int i = 0; i < NC; i++) chk("core_key", core_key[i*KW +: KW], key_of[i]);
        if (core_start != '0) begin
            obs_cnt++;
            k = int'(current_key);
            if (seen[k]) dup++;
            seen[k] = 1;
            if (k > obs_max) obs_max = k;
        end
        for (int i = 0; i < NC; i++) begin
            drv_done[i] = bsy[i] && (done_edge[i] == edge_n + 1);
            drv_succ[i] = drv_done[i] && is_succ(key_of[i]);
        end
        core_done    = drv_done;
        core_success = drv_succ;
    endtask

    task automatic start_sweep();
        rc4_start = 1'b1;
        tick();
        rc4_start = 1'b0;
    endtask

    task automatic run_to_end();
        int k = 0;
        while (running && k < 3000) begin
            tick();
            k++;
        end
        chk("sweep_timeout", running, 0);
    endtask

    // Keys 0..3 to cores 0..3 on consecutive cycles, then key 4 to the first core freed.
    task automatic check_first_dispatches(input bit with_refill);
        logic [NC-1:0] one;
        int k;
        one = 1;
        for (int i = 0; i < NC; i++) begin
            tick();
            chk("first_core", core_start, one << i);
            chk("first_key",  core_key[i*KW +: KW], i);
        end
        if (with_refill) begin
            k = 0;
            do begin tick(); k++; end while (core_start == '0 && k < 20);
            chk("refill_core", core_start, one);
            chk("refill_key",  current_key, 4);
        end
    endtask

    initial begin
        reset = 1'b1; rc4_start = 1'b0;
        core_done = '0; core_success = '0; drv_done = '0; drv_succ = '0;
        rst_b = 1'b1; start_b = 1'b0; cd_b = '0; csucc_b = '0;
        for (int i = 0; i < NC; i++) lat[i] = 10;
        model_reset();
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("reset_ready", rc4_ready, 1);
        chk("reset_start", core_start, 0);

        // Success only on key 0x25
        succ_mode = 1;
        start_sweep();
        check_first_dispatches(1'b1);
        run_to_end();
        chk("succ_found",   found_key, 8'h25);
        chk("succ_finish",  rc4_finish, 1);
        chk("succ_failure", rc4_failure, 0);
        chk("succ_ready",   rc4_ready, 1);
        chk("succ_max_key", obs_max <= 8'h28, 1);
        tick(); tick();

        // Exhaustion: every key 0..63 exactly once, then failure
        succ_mode = 0;
        start_sweep();
        run_to_end();
        chk("exh_count",   obs_cnt, 64);
        chk("exh_dup",     dup, 0);
        chk("exh_failure", rc4_failure, 1);
        chk("exh_finish",  rc4_finish, 0);
        tick(); tick(); tick();

        // Cores 1 and 3 succeed at the same edge; core 1 wins
        succ_mode = 2;
        lat[1] = 12;
        start_sweep();
        check_first_dispatches(1'b0);
        run_to_end();
        chk("simul_found",  found_key, 1);
        chk("simul_finish", rc4_finish, 1);
        lat[1] = 10;
        tick();

        // Reset in the middle of a sweep, then restart from key 0
        succ_mode = 0;
        start_sweep();
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_ready", rc4_ready, 1);
        chk("mid_rst_fail",  rc4_failure, 0);
        chk("mid_rst_start", core_start, 0);
        chk("mid_rst_key",   current_key, 0);
        chk("mid_rst_found", found_key, 0);
        tick();
        succ_mode = 1;
        start_sweep();
        check_first_dispatches(1'b0);
        run_to_end();
        chk("restart_found", found_key, 8'h25);

        // Narrow instance: KEY_MAX = 4'hF must end after 16 keys with no wrap
        rst_b = 1'b0;
        tick();
        chk("b_ready", ready_b, 1);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        begin
            int expk = 0, pend = -1, k = 0;
            while (!failure_b && k < 400) begin
                tick();
                k++;
                cd_b = '0;
                if (cs_b[0]) begin
                    chk("b_key", ck_b, expk);
                    chk("b_cur", cur_b, expk);
                    expk++;
                    pend = edge_n + 3;
                end
                if (edge_n + 1 == pend) cd_b = 1'b1;
            end
            chk("b_failure", failure_b, 1);
            chk("b_count",   expk, 16);
            chk("b_finish",  finish_b, 0);
            chk("b_found",   found_b, 0);
            chk("b_abort",   ca_b, 0);
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("b_no_wrap", cs_b, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rc4_key_dispatcher.md
Name: rc4_key_dispatcher

Overview:
- Parametrised successor to the single-pipeline RC4 brute-force cracker.
- Sweeps the key space 0..KEY_MAX across NUM_CORES external RC4 decrypt/check cores using dynamic dispatch: the next untested key goes to the lowest-index idle core.
- Reports the first key whose plaintext passes the core's check, or failure once the space is exhausted.
- Sits between the top-level control/HEX display and the replicated rc4 core instances.

Parameters:
- NUM_CORES, 4, number of attached cores (1..16).
- KEY_WIDTH, 24, key width in bits.
- KEY_MAX, 24'h3FFFFF, last key tested (inclusive).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- rc4_start  in  1  one-cycle request to begin a sweep; accepted only while rc4_ready=1
- rc4_ready  out  1  high in IDLE, DONE_OK and DONE_FAIL
- rc4_finish  out  1  high in DONE_OK
- rc4_failure  out  1  high in DONE_FAIL
- current_key  out  KEY_WIDTH  most recently dispatched key
- found_key  out  KEY_WIDTH  successful key; valid while rc4_finish=1
- core_start  out  NUM_CORES  one-cycle dispatch pulse per core
- core_key  out  NUM_CORES*KEY_WIDTH  per-core key; slice i held stable while core i is busy
- core_done  in  NUM_CORES  one-cycle completion pulse per core
- core_success  in  NUM_CORES  qualifies core_done; plaintext passed the check
- core_abort  out  NUM_CORES  abort pulse (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, rc4_ready=1, rc4_finish=0, rc4_failure=0.
  - current_key=0, found_key=0, core_key=0, core_start=0, core_abort=0.
  - busy[]=0, next-key counter=0.
  - Reset mid-sweep abandons all work; cores share the same reset.
- Next-key counter is KEY_WIDTH+1 bits so that KEY_MAX = all-ones terminates without wrap to 0.
- IDLE / DONE_OK / DONE_FAIL: on rc4_start, clear the counter, busy[], finish and failure; go to RUN next cycle. rc4_start in any other state is ignored.
- RUN, each cycle:
  - If no success is reported this cycle, the counter <= KEY_MAX, and some core is idle: pulse core_start for the lowest-index idle core, load its core_key slice and current_key with the counter, set busy, increment the counter.
  - At most one dispatch per cycle. First dispatch (key 0 to core 0) occurs the cycle after start is accepted.
- Completion: core_done[i] with busy[i] clears busy[i] at the edge; the core is dispatchable from the next cycle. core_done from a non-busy core is ignored.
- Success: any (core_done & core_success & busy) captures found_key from the lowest-index such core, and dispatch is suppressed in that cycle.
  - Without the optional feature: go to FLUSH.
  - With the optional feature: go to DONE_OK (see Optional Feature).
- FLUSH: no dispatch. Later done/success pulses are ignored and found_key is unchanged. When busy[]=0, go to DONE_OK.
- Exhaustion (RUN): counter > KEY_MAX and busy[]=0 with no success, go to DONE_FAIL.
- Status outputs are registered. rc4_finish / rc4_failure assert the cycle after the terminating condition and hold until the next accepted rc4_start.

Optional Feature:
- Macro RC4_DISPATCH_ABORT_EN.
- Defined: on success, core_abort pulses for one cycle on every core still busy other than the winner, busy[] clears, and the state goes directly to DONE_OK. FLUSH is unused.
- Undefined: core_abort is tied to 0 and the FLUSH drain is used.

Decomposition:
- Package rc4_cracker_pkg holds:
  - state enum {IDLE, RUN, FLUSH, DONE_OK, DONE_FAIL};
  - default KEY_WIDTH and KEY_MAX constants.
- One sub-module, rc4_prio_enc: parametrised lowest-set-bit encoder returning index and valid. Used for both idle-core selection and winner selection.

Test Plan (NUM_CORES=4, KEY_MAX=63, behavioural core models with fixed latency L=10 unless stated):
- Reset and start: rc4_ready=1 after reset. Pulse rc4_start → core_start on cores 0,1,2,3 in consecutive cycles with keys 0,1,2,3. After the first done, key 4 goes to that core.
- Success: model succeeds only on key 0x25 → found_key=0x25, rc4_finish=1, rc4_failure=0. No key >0x25+3 is dispatched after the success cycle. rc4_ready=1.
- Exhaustion: no key succeeds → exactly 64 dispatches (keys 0..63, each once), then rc4_failure=1, rc4_finish=0.
- Simultaneous success: cores 1 and 3 report done+success in the same cycle → found_key equals core 1's key.
- Boundary: KEY_WIDTH=4, KEY_MAX=4'hF, no success → 16 dispatches, no wrap to key 0, DONE_FAIL.
- Reset mid-sweep, then restart: assert reset during RUN → all outputs return to reset values. A new rc4_start restarts at key 0. With RC4_DISPATCH_ABORT_EN, success asserts core_abort for the other busy cores and rc4_finish the next cycle.
